// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: set at issue, cleared at writeback, issue wins a same-cycle tie.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned NUM_WR   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Clears are applied first so a same-cycle issue overrides them.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (wr_en[k]) begin
                busy_d[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port MIPS register file with optional write-to-read bypass and RAW scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_ADDR);

    logic [DATA_W-1:0] regs_q [DEPTH];

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec)
    );

    // Later ports are visited last, so the highest index wins an address clash.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] &&
                    !(ZERO_REG != 0 && wr_addr[k*ADDR_W +: ADDR_W] == ZERO_IDX)) begin
                    regs_q[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
            rd_busy[i]                  = busy_vec[rd_addr[i*ADDR_W +: ADDR_W]];
            if (BYPASS != 0 && !rst) begin
                for (int unsigned k = 0; k < NUM_WR; k++) begin
                    if (wr_en[k] &&
                        wr_addr[k*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W]) begin
                        rd_data[i*DATA_W +: DATA_W] = wr_data[k*DATA_W +: DATA_W];
                        rd_busy[i]                  = 1'b0;
                    end
                end
            end
            if (ZERO_REG != 0 && rd_addr[i*ADDR_W +: ADDR_W] == ZERO_IDX) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomized and directed check of regfile_mp_sb (bypass and non-bypass builds) against an array model.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;

    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic [31:0] busy_vec_b, busy_vec_n;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bit [31:0] m_mem  [32];
    bit        m_busy [32];

    always #5 clk = ~clk;

    regfile_mp_sb #(
        .DATA_W (32), .ADDR_W (5), .NUM_RD (2), .NUM_WR (2), .BYPASS (1), .ZERO_REG (1)
    ) u_dut_byp (
        .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data_b), .rd_busy (rd_busy_b),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .iss_en (iss_en), .iss_addr (iss_addr), .busy_vec (busy_vec_b)
    );

    regfile_mp_sb #(
        .DATA_W (32), .ADDR_W (5), .NUM_RD (2), .NUM_WR (2), .BYPASS (0), .ZERO_REG (1)
    ) u_dut_nob (
        .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data_n), .rd_busy (rd_busy_n),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .iss_en (iss_en), .iss_addr (iss_addr), .busy_vec (busy_vec_n)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [4:0] wa(input int k);
        return wr_addr[k*5 +: 5];
    endfunction

    function automatic bit [31:0] wd(input int k);
        return wr_data[k*32 +: 32];
    endfunction

    // Reference read: zero register, then newest forwarded write, then stored value.
    function automatic bit [31:0] exp_data(input bit [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && !rst) begin
            for (int k = 1; k >= 0; k--)
                if (wr_en[k] && wa(k) == a) return wd(k);
        end
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input bit [4:0] a, input bit byp);
        if (byp && !rst) begin
            for (int k = 0; k < 2; k++)
                if (wr_en[k] && wa(k) == a) return 1'b0;
        end
        return m_busy[a];
    endfunction

    function automatic bit [31:0] model_vec();
        bit [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_mem[r]  = 32'h0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic model_clock();
        bit hit;
        if (rst) begin
            model_reset();
            return;
        end
        for (int r = 1; r < 32; r++) begin
            hit = 1'b0;
            for (int k = 0; k < 2; k++)
                if (wr_en[k] && wa(k) == r) hit = 1'b1;
            if (iss_en && iss_addr == r) m_busy[r] = 1'b1;
            else if (hit)                m_busy[r] = 1'b0;
        end
        for (int k = 0; k < 2; k++)
            if (wr_en[k] && wa(k) != 0) m_mem[wa(k)] = wd(k);
    endtask

    task automatic comb_phase();
        bit [4:0] a;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            a = rd_addr[i*5 +: 5];
            check_eq($sformatf("rd_data_byp[%0d]", i), rd_data_b[i*32 +: 32], exp_data(a, 1'b1));
            check_eq($sformatf("rd_data_nob[%0d]", i), rd_data_n[i*32 +: 32], exp_data(a, 1'b0));
            check_eq($sformatf("rd_busy_byp[%0d]", i), rd_busy_b[i], exp_busy(a, 1'b1));
            check_eq($sformatf("rd_busy_nob[%0d]", i), rd_busy_n[i], exp_busy(a, 1'b0));
        end
    endtask

    task automatic edge_phase();
        @(posedge clk);
        model_clock();
        #1;
        check_eq("busy_vec_byp", busy_vec_b, model_vec());
        check_eq("busy_vec_nob", busy_vec_n, model_vec());
    endtask

    task automatic idle();
        rst    = 1'b0;
        wr_en  = '0;
        iss_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        check_eq("reset_busy_vec", busy_vec_b, 32'h0);
        idle();

        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            comb_phase();
            check_eq("reset_rd0", rd_data_b[31:0], 32'h0);
            check_eq("reset_rd1", rd_data_n[63:32], 32'h0);
            edge_phase();
        end

        // Same-cycle bypass of a write to r5
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        rd_addr = {5'd0, 5'd5};
        comb_phase();
        check_eq("bypass_r5_byp", rd_data_b[31:0], 32'hDEADBEEF);
        check_eq("bypass_r5_nob", rd_data_n[31:0], 32'h0);
        edge_phase();
        idle();
        comb_phase();
        check_eq("stored_r5_byp", rd_data_b[31:0], 32'hDEADBEEF);
        check_eq("stored_r5_nob", rd_data_n[31:0], 32'hDEADBEEF);
        edge_phase();

        // Zero register ignores writes and issue
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h12345678};
        iss_en = 1'b1; iss_addr = 5'd0; rd_addr = {5'd0, 5'd0};
        comb_phase();
        check_eq("zero_bypass", rd_data_b[31:0], 32'h0);
        edge_phase();
        check_eq("zero_not_busy", busy_vec_b[0], 1'b0);
        idle();
        comb_phase();
        check_eq("zero_stored", rd_data_n[31:0], 32'h0);
        edge_phase();

        // Two write ports hit r7: port 1 wins
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
        rd_addr = {5'd7, 5'd7};
        comb_phase();
        check_eq("dual_wr_bypass", rd_data_b[31:0], 32'h22);
        edge_phase();
        idle();
        comb_phase();
        check_eq("dual_wr_stored", rd_data_n[31:0], 32'h22);
        edge_phase();

        // Scoreboard: issue r9, issue+writeback r9, lone writeback r9
        iss_en = 1'b1; iss_addr = 5'd9; rd_addr = {5'd9, 5'd9};
        comb_phase();
        check_eq("iss_not_same_cycle", rd_busy_b[0], 1'b0);
        edge_phase();
        check_eq("iss_busy_vec9", busy_vec_b[9], 1'b1);
        idle();
        comb_phase();
        check_eq("iss_rd_busy", rd_busy_b[0], 1'b1);
        edge_phase();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
        iss_en = 1'b1; iss_addr = 5'd9;
        comb_phase();
        edge_phase();
        check_eq("set_beats_clear", busy_vec_b[9], 1'b1);
        iss_en = 1'b0;
        comb_phase();
        check_eq("wb_fwd_rd_busy", rd_busy_b[0], 1'b0);
        check_eq("wb_nofwd_rd_busy", rd_busy_n[0], 1'b1);
        edge_phase();
        check_eq("wb_clears", busy_vec_b[9], 1'b0);
        idle();

        // Reset discards a concurrent write and clears state
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hAA};
        comb_phase(); edge_phase();
        idle(); iss_en = 1'b1; iss_addr = 5'd3;
        comb_phase(); edge_phase();
        check_eq("r3_busy", busy_vec_b[3], 1'b1);
        idle(); rst = 1'b1; wr_en = 2'b01; wr_data = {32'h0, 32'h55}; rd_addr = {5'd3, 5'd3};
        comb_phase();
        check_eq("rst_no_bypass", rd_data_b[31:0], 32'hAA);
        edge_phase();
        idle();
        comb_phase();
        check_eq("rst_r3_cleared", rd_data_b[31:0], 32'h0);
        check_eq("rst_busy_vec", busy_vec_b, 32'h0);
        edge_phase();

        // Random traffic with a narrow address range to force collisions
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 39) == 0);
            wr_en  = 2'($urandom);
            iss_en = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 2; k++) begin
                wr_addr[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                wr_data[k*32 +: 32] = $urandom;
                rd_addr[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            end
            iss_addr = 5'($urandom_range(0, 7));
            comb_phase();
            edge_phase();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
